scie_fir_mc: RTL
================

Name: scie_fir_mc

Overview:
- Parametrised successor to the single-channel pipelined SCIE FIR custom-instruction unit.
- Holds CHANNELS independent FIR filters, each with TAPS programmable coefficients and its own sample delay line.
- Computes each dot product with one time-multiplexed multiply-accumulate (MAC) over TAPS cycles.
- Sits beside the core as a SCIE custom-instruction slave: decodes io_insn opcode and returns results on io_rd.

Parameters:
- XLEN, 32, width of rs1/rs2/rd.
- TAPS, 5, taps per channel (>=2).
- CHANNELS, 2, independent filter channels (>=1).
- DATA_W, 16, signed sample width, taken from rs1[DATA_W-1:0].
- COEF_W, 16, signed coefficient width, taken from rs1[COEF_W-1:0].

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- io_valid  in  1  instruction valid this cycle.
- io_insn  in  XLEN  instruction word; opcode = io_insn[6:0].
- io_rs1  in  XLEN  operand 1: coefficient or sample value.
- io_rs2  in  XLEN  operand 2: index fields.
- io_rd  out  XLEN  registered result.
- io_rd_valid  out  1  pulses one cycle after an accepted READ or STATUS.
- io_busy  out  1  MAC sequencer running.

Behaviour:
- Reset (reset low, async): all outputs are 0.
  - Coefficients, delay lines, results, sequencer state and the overflow flag clear to 0.
- Field extraction: ch = rs2[15:8] mod CHANNELS; idx = rs2[7:0].
- Opcodes are decoded only when io_valid=1. Unknown opcodes are ignored.
- 0x0B SETCOEF: coef[ch][idx] <= rs1[COEF_W-1:0].
  - Ignored when idx >= TAPS.
  - Also ignored when ch equals the active channel while busy.
- 0x2B PUSH, accepted only when idle:
  - Delay line of ch shifts; newest sample = rs1[DATA_W-1:0].
  - Sequencer starts on channel ch.
  - If busy, the push is dropped and sticky ovf <= 1. The delay line is unchanged.
- 0x5B READ: next cycle io_rd <= sign-extended result[ch] and io_rd_valid=1.
  - Allowed while busy; returns the last completed result.
- 0x7B STATUS: next cycle io_rd <= {ovf, busy, active ch} in low bits, with io_rd_valid=1.
  - ovf clears on the same cycle.
- Sequencer FSM, IDLE -> MAC -> DONE -> IDLE:
  - IDLE: busy=0.
  - MAC: one tap per cycle, k = 0..TAPS-1. acc += x[k]*coef[k], where x[0] is the newest sample.
  - DONE: result[ch] <= acc. Returns to IDLE the next cycle.
  - A PUSH accepted at cycle 0 makes busy high for cycles 1..TAPS+1.
  - The result becomes readable by a READ issued at cycle TAPS+2, returned at TAPS+3.
- Arithmetic:
  - Products are signed DATA_W+COEF_W.
  - acc width ACC_W = DATA_W+COEF_W+clog2(TAPS).
  - Result = acc truncated/sign-extended to XLEN.
- Simultaneous events:
  - A PUSH in the same cycle as DONE is dropped and ovf is set; idle is required at the decode cycle.
  - The result write in DONE and a READ of the same channel in the same cycle: the READ returns the old value.
- Reset asserted mid-MAC: accumulation is abandoned; every register returns to its reset value.

Optional Feature:
- Macro: SCIE_FIR_SAT_EN.
- Defined: in DONE, acc saturates to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1] before storing.
  - STATUS bit sat is set sticky whenever clipping occurs, and clears on a STATUS read.
- Undefined: plain truncation. The sat bit reads 0.

Decomposition:
- Package scie_fir_pkg:
  - opcode constants OP_SETCOEF=7'h0B, OP_PUSH=7'h2B, OP_READ=7'h5B, OP_STATUS=7'h7B.
  - FSM state enum {IDLE, MAC, DONE}.
  - STATUS bit-position constants.
- One sub-module, scie_fir_mac: signed multiply-accumulate with clear/enable, parametrised on DATA_W/COEF_W/ACC_W.
- Storage, decode and FSM stay in the top.

Test Plan:
1. Identity filter: SETCOEF ch0 coef = {1,0,0,0,0}; PUSH 15 to ch0; wait 3 cycles after busy falls; READ ch0 -> io_rd=15, io_rd_valid=1 for one cycle.
2. Moving sum: ch1 coefs all 1; PUSH 1,2,3,4,5, each after busy falls; READ ch1 -> 15. PUSH 10 -> 24. READ ch0 is unchanged (15).
3. Overflow: PUSH 7 to ch0, then PUSH 9 on the next cycle while busy -> second push dropped. STATUS -> ovf=1. A second STATUS -> ovf=0. Result = 7 with identity coefs.
4. Negative math: coef[0]=-3 (rs1=32'hFFFFFFFD); PUSH -4 -> READ returns 12. PUSH 5 -> READ returns 32'hFFFFFFF1 (-15).
5. Reset mid-MAC: PUSH 20 to ch0, pull reset low at cycle 2 of MAC -> io_busy=0 and io_rd=0 immediately. After release, READ ch0 -> 0 and all coefs read back as 0 through the identity-style test.
6. SCIE_FIR_SAT_EN only: coef[0]=32767; PUSH 32767 -> READ 32767 and STATUS sat=1. Without the macro -> READ returns 32767*32767 = 1073676289.

Source files
------------

// File: rtl/scie_fir_pkg.sv
// scie_fir_pkg: shared constants for the multi-channel SCIE FIR unit.
//   - custom-instruction opcodes (io_insn[6:0])
//   - sequencer state encoding
//   - STATUS word bit positions
package scie_fir_pkg;

    localparam logic [6:0] OP_SETCOEF = 7'h0B;
    localparam logic [6:0] OP_PUSH    = 7'h2B;
    localparam logic [6:0] OP_READ    = 7'h5B;
    localparam logic [6:0] OP_STATUS  = 7'h7B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    // STATUS word: {sat, ovf, busy, active_ch[7:0]} packed into the low bits.
    localparam int ST_CH_LSB   = 0;
    localparam int ST_CH_W     = 8;
    localparam int ST_BUSY_BIT = 8;
    localparam int ST_OVF_BIT  = 9;
    localparam int ST_SAT_BIT  = 10;

endpackage

// File: rtl/scie_fir_mac.sv
// scie_fir_mac: signed multiply-accumulate with synchronous clear and enable.
// Ports:
//   clock, reset     clock, async active-low reset
//   clr              zero the accumulator (wins over en)
//   en               acc += sample * coef
//   sample, coef     signed operands
//   acc              registered accumulator
module scie_fir_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    assign prod = sample * coef;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/scie_fir_mc.sv
// scie_fir_mc: multi-channel FIR custom-instruction slave. CHANNELS filters of
// TAPS programmable taps share one time-multiplexed MAC; a PUSH starts a
// TAPS-cycle dot product on its channel.
// Ports:
//   clock, reset            clock, async active-low reset
//   io_valid, io_insn       instruction strobe and word (opcode = insn[6:0])
//   io_rs1, io_rs2          value operand; index fields {ch[15:8], idx[7:0]}
//   io_rd, io_rd_valid      registered READ/STATUS result and its pulse
//   io_busy                 sequencer running
// Optional build macro: SCIE_FIR_SAT_EN saturates results to the sample range
// and reports clipping in the STATUS sat bit.
//
// state | meaning
// IDLE  | waiting for PUSH, busy low
// MAC   | one tap per cycle, taps 0..TAPS-1 (down-counter reaches 0 on last)
// DONE  | store accumulator into the channel result, then back to IDLE
module scie_fir_mc #(
    parameter int XLEN     = 32,
    parameter int TAPS     = 5,
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [XLEN-1:0] io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic [XLEN-1:0] io_rd,
    output logic            io_rd_valid,
    output logic            io_busy
);
    import scie_fir_pkg::*;

    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int TW    = $clog2(TAPS);
    localparam int CH_IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int EXT_W = (XLEN > ACC_W) ? XLEN : ACC_W;
    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

    fir_state_e              state_q, state_d;
    logic [TW-1:0]           cnt_q, cnt_d;
    logic [CH_IW-1:0]        act_ch_q, act_ch_d;
    logic signed [COEF_W-1:0] coef_q [CHANNELS][TAPS];
    logic signed [COEF_W-1:0] coef_d [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] x_q [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] x_d [CHANNELS][TAPS];
    logic [XLEN-1:0]         res_q [CHANNELS];
    logic [XLEN-1:0]         res_d [CHANNELS];
    logic                    ovf_q, ovf_d;
    logic [XLEN-1:0]         rd_q, rd_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [6:0]              opcode;
    logic [31:0]             ch_full;
    logic [CH_IW-1:0]        ch;
    logic [TW-1:0]           idx;
    logic                    idx_ok;
    logic                    busy;
    logic                    is_setcoef, is_push, is_read, is_status;
    logic                    push_go, push_drop;
    logic [TW-1:0]           tap;
    logic signed [ACC_W-1:0] acc, acc_sel;
    logic signed [EXT_W-1:0] acc_ext;
    logic                    clip;

    assign opcode     = io_insn[6:0];
    assign ch_full    = 32'(io_rs2[15:8]) % CHANNELS;
    assign ch         = ch_full[CH_IW-1:0];
    assign idx        = io_rs2[TW-1:0];
    assign idx_ok     = 32'(io_rs2[7:0]) < TAPS;
    assign busy       = (state_q != IDLE);
    assign is_setcoef = io_valid && (opcode == OP_SETCOEF);
    assign is_push    = io_valid && (opcode == OP_PUSH);
    assign is_read    = io_valid && (opcode == OP_READ);
    assign is_status  = io_valid && (opcode == OP_STATUS);
    // Idle is judged at the decode cycle, so a PUSH during DONE is dropped.
    assign push_go    = is_push && !busy;
    assign push_drop  = is_push && busy;
    assign tap        = LAST_TAP - cnt_q;

    scie_fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clr    (push_go),
        .en     (state_q == MAC),
        .sample (x_q[act_ch_q][tap]),
        .coef   (coef_q[act_ch_q][tap]),
        .acc    (acc)
    );

`ifdef SCIE_FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic sat_q, sat_d;

    always_comb begin
        acc_sel = acc;
        clip    = 1'b0;
        if (acc > SAT_MAX) begin
            acc_sel = SAT_MAX;
            clip    = 1'b1;
        end else if (acc < SAT_MIN) begin
            acc_sel = SAT_MIN;
            clip    = 1'b1;
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (is_status) begin
            sat_d = 1'b0;
        end
        // A clip landing on the same cycle as a STATUS read must not be lost.
        if (state_q == DONE && clip) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    assign acc_sel = acc;
    assign clip    = 1'b0;
`endif

    assign acc_ext = EXT_W'(acc_sel);

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (push_go) begin
                    state_d = MAC;
                    cnt_d   = LAST_TAP;
                end
            end
            MAC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Storage, decode and result path.
    always_comb begin
        coef_d     = coef_q;
        x_d        = x_q;
        res_d      = res_q;
        act_ch_d   = act_ch_q;
        ovf_d      = ovf_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;

        // Coefficients of the channel being accumulated are frozen.
        if (is_setcoef && idx_ok && !(busy && ch == act_ch_q)) begin
            coef_d[ch][idx] = io_rs1[COEF_W-1:0];
        end

        if (push_go) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                x_d[ch][k] = x_q[ch][k-1];
            end
            x_d[ch][0] = io_rs1[DATA_W-1:0];
            act_ch_d   = ch;
        end

        // READ samples res_q, so it sees the old value during DONE's write.
        if (is_read) begin
            rd_d       = res_q[ch];
            rd_valid_d = 1'b1;
        end

        if (is_status) begin
            rd_d                         = '0;
            rd_d[ST_CH_LSB +: ST_CH_W]   = ST_CH_W'(act_ch_q);
            rd_d[ST_BUSY_BIT]            = busy;
            rd_d[ST_OVF_BIT]             = ovf_q;
`ifdef SCIE_FIR_SAT_EN
            rd_d[ST_SAT_BIT]             = sat_q;
`endif
            rd_valid_d                   = 1'b1;
            ovf_d                        = 1'b0;
        end

        if (push_drop) begin
            ovf_d = 1'b1;
        end

        if (state_q == DONE) begin
            res_d[act_ch_q] = acc_ext[XLEN-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_ch_q   <= '0;
            ovf_q      <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                res_q[c] <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    coef_q[c][k] <= '0;
                    x_q[c][k]    <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_ch_q   <= act_ch_d;
            ovf_q      <= ovf_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            res_q      <= res_d;
            coef_q     <= coef_d;
            x_q        <= x_d;
        end
    end

    assign io_rd       = rd_q;
    assign io_rd_valid = rd_valid_q;
    assign io_busy     = busy;

    // Operand bits beyond the decoded fields and the clipped-off accumulator bits.
    logic unused_bits;
    assign unused_bits = ^{io_insn, io_rs1, io_rs2, acc_ext, ch_full, clip};

endmodule
